// File: rtl/softmax_ctrl_pkg.sv
// Shared types and constants for the softmax sequencer.
// Stage latencies are measured in cycles after a phase's read-valid.

package softmax_ctrl_pkg;

    // Lanes per memory word; the sequencer itself is lane-agnostic.
    localparam int NUM = 4;

    // Max pass: the max register loads one cycle after its read.
    localparam int MAX_LAT = 1;

    // First subtract pass: sub -> exp -> accumulate.
    localparam int SUB_LAT = 1;
    localparam int EXP_LAT = 2;
    localparam int ACC_LAT = 3;

    // Normalise pass: presub -> logsub -> out-exp -> valid output word.
    localparam int PRESUB_LAT = 1;
    localparam int LOGSUB_LAT = 2;
    localparam int OUTEXP_LAT = 3;
    localparam int OUT_LAT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAX   = 3'd1,
        ST_SUB   = 3'd2,
        ST_LOG   = 3'd3,
        ST_NORM  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // A phase has fully drained when its read stream is idle and the given
    // pipeline stage is on its final strobe (stage active, previous stage idle).
    function automatic logic stage_last(input logic rd_valid,
                                        input logic stage_en,
                                        input logic prev_en);
        return !rd_valid && stage_en && !prev_en;
    endfunction

endpackage

// File: rtl/softmax_phase_seq.sv
// One read phase: an address counter that walks 0..N-1 after a go pulse,
// the matching read-valid, and a delay line that turns read-valid into the
// per-stage register enables of that phase's pipeline.

module softmax_phase_seq #(
    parameter int AW    = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,     // accepted start: counter back to 0
    input  logic             go_i,        // phase streams from next cycle
    input  logic [AW-1:0]    n_i,         // word count, nonzero when go_i fires
    output logic [AW-1:0]    addr_o,
    output logic             rd_valid_o,
    output logic [DEPTH-1:0] en_o         // en_o[i] = rd_valid delayed i+1
);

    logic             active_q, active_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] dly_q, dly_d;
    logic             last;

    // Counter stops on N-1 and holds it, so N up to 2^AW-1 never wraps.
    assign last = active_q && (cnt_q == (n_i - AW'(1)));

    // Address counter and read-valid next state.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d    = '0;
            active_d = go_i;
        end else if (go_i) begin
            active_d = 1'b1;
        end else if (active_q) begin
            if (last) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    // Enable delay line: each tap is one more register stage downstream.
    always_comb begin
        dly_d    = '0;
        dly_d[0] = active_q;
        for (int i = 1; i < DEPTH; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            dly_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
        end
    end

    assign addr_o     = cnt_q;
    assign rd_valid_o = active_q;
    assign en_o       = dly_q;

endmodule

// File: rtl/softmax_ctrl.sv
// Central sequencer for the 4-lane softmax datapath. One FSM steps through
// the max pass, the subtract/exp/accumulate pass, the single log load and
// the normalise pass; three phase sequencers generate the read addresses
// and the stage enables of each pass.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; N latched on the accepting cycle
// MAX   | max-pass addresses streaming, then final max_en
// SUB   | first-subtract addresses streaming, sub/exp/acc pipeline tail
// LOG   | one-cycle log register load, kicks off the normalise stream
// NORM  | normalise-pass addresses streaming
// DRAIN | presub/logsub/outexp/out_valid tail after the stream ends
// DONE  | one-cycle done pulse; start ignored here

module softmax_ctrl
    import softmax_ctrl_pkg::*;
#(
    parameter int ADDRSIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] addr_limit,
    output logic [ADDRSIZE-1:0] addr,
    output logic [ADDRSIZE-1:0] sub0_inp_addr,
    output logic [ADDRSIZE-1:0] sub1_inp_addr,
    output logic                clr,
    output logic                max_en,
    output logic                sub_en,
    output logic                exp_en,
    output logic                acc_en,
    output logic                log_en,
    output logic                presub_en,
    output logic                logsub_en,
    output logic                outexp_en,
    output logic                out_valid,
    output logic [ADDRSIZE-1:0] out_idx,
    output logic                busy,
    output logic                done
);

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] n_q, n_d;
    logic                clr_q, clr_d;
    logic [ADDRSIZE-1:0] out_cnt_q, out_cnt_d;

    logic start_acc;
    logic go_max, go_sub, go_norm;
    logic max_rd, sub_rd, norm_rd;

    logic [MAX_LAT-1:0] max_v;
    logic [ACC_LAT-1:0] sub_v;
    logic [OUT_LAT-1:0] norm_v;

    // start is a level; it only counts while the FSM sits in IDLE.
    assign start_acc = (state_q == ST_IDLE) && start;
    // N is latched this same cycle, so the run length comes straight off the port.
    assign go_max    = start_acc && (addr_limit != '0);

    softmax_phase_seq #(.AW(ADDRSIZE), .DEPTH(MAX_LAT)) u_max (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_acc),
        .go_i       (go_max),
        .n_i        (addr_limit),
        .addr_o     (addr),
        .rd_valid_o (max_rd),
        .en_o       (max_v)
    );

    // Counters of the later phases are cleared at start, so their go pulses
    // only need to raise read-valid.
    softmax_phase_seq #(.AW(ADDRSIZE), .DEPTH(ACC_LAT)) u_sub (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_acc),
        .go_i       (go_sub),
        .n_i        (n_q),
        .addr_o     (sub0_inp_addr),
        .rd_valid_o (sub_rd),
        .en_o       (sub_v)
    );

    softmax_phase_seq #(.AW(ADDRSIZE), .DEPTH(OUT_LAT)) u_norm (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_acc),
        .go_i       (go_norm),
        .n_i        (n_q),
        .addr_o     (sub1_inp_addr),
        .rd_valid_o (norm_rd),
        .en_o       (norm_v)
    );

    assign max_en    = max_v[MAX_LAT-1];
    assign sub_en    = sub_v[SUB_LAT-1];
    assign exp_en    = sub_v[EXP_LAT-1];
    assign acc_en    = sub_v[ACC_LAT-1];
    assign presub_en = norm_v[PRESUB_LAT-1];
    assign logsub_en = norm_v[LOGSUB_LAT-1];
    assign outexp_en = norm_v[OUTEXP_LAT-1];
    assign out_valid = norm_v[OUT_LAT-1];

    // Phase transitions wait for each pipeline tail so that enables of
    // consecutive phases never overlap.
    always_comb begin
        state_d = state_q;
        go_sub  = 1'b0;
        go_norm = 1'b0;
        log_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (addr_limit == '0) ? ST_DONE : ST_MAX;
                end
            end
            ST_MAX: begin
                busy = 1'b1;
                if (!max_rd && max_en) begin
                    go_sub  = 1'b1;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                busy = 1'b1;
                if (stage_last(sub_rd, acc_en, exp_en)) begin
                    state_d = ST_LOG;
                end
            end
            ST_LOG: begin
                busy    = 1'b1;
                log_en  = 1'b1;
                go_norm = 1'b1;
                state_d = ST_NORM;
            end
            ST_NORM: begin
                busy = 1'b1;
                if (!norm_rd && presub_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (stage_last(norm_rd, out_valid, outexp_en)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run length latch, clear pulse and output word index.
    always_comb begin
        n_d       = n_q;
        clr_d     = go_max;
        out_cnt_d = out_cnt_q;
        if (start_acc) begin
            n_d       = addr_limit;
            out_cnt_d = '0;
        end else if (out_valid && (out_cnt_q != (n_q - ADDRSIZE'(1)))) begin
            out_cnt_d = out_cnt_q + ADDRSIZE'(1);
        end
    end

    // Control registers; reset aborts a run without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            clr_q     <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            clr_q     <= clr_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign clr     = clr_q;
    assign out_idx = out_valid ? out_cnt_q : '0;

endmodule

// File: tb/tb_softmax_ctrl.sv
// Scoreboard bench for softmax_ctrl: a cycle-window model of every strobe,
// expected output words and done pulses queued at start acceptance, and a
// negedge monitor that pops and compares whenever the DUT presents them.

module tb_softmax_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] addr_limit = '0;

    logic [AW-1:0] addr, sub0_inp_addr, sub1_inp_addr, out_idx;
    logic clr, max_en, sub_en, exp_en, acc_en, log_en;
    logic presub_en, logsub_en, outexp_en, out_valid, busy, done;

    softmax_ctrl #(.ADDRSIZE(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .addr_limit    (addr_limit),
        .addr          (addr),
        .sub0_inp_addr (sub0_inp_addr),
        .sub1_inp_addr (sub1_inp_addr),
        .clr           (clr),
        .max_en        (max_en),
        .sub_en        (sub_en),
        .exp_en        (exp_en),
        .acc_en        (acc_en),
        .log_en        (log_en),
        .presub_en     (presub_en),
        .logsub_en     (logsub_en),
        .outexp_en     (outexp_en),
        .out_valid     (out_valid),
        .out_idx       (out_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int idx;
    } out_t;

    out_t out_q[$];
    int   done_q[$];

    int cyc = 0;
    bit model_ok = 1'b0;
    bit have_run = 1'b0;
    int m_c0 = 0;
    int m_n = 0;
    int run_id = 0;
    int runs_expected = 0;
    int dones_seen = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit win(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    function automatic int clampk(input int k, input int base, input int n);
        if (n == 0 || k < base) return 0;
        return (k - base > n - 1) ? n - 1 : k - base;
    endfunction

    // Bit order: clr max sub exp acc log presub logsub outexp out_valid busy done
    function automatic logic [11:0] exp_strb(input int k, input int n);
        logic [11:0] v;
        v = '0;
        if (n == 0) begin
            v[0] = (k == 1);
        end else begin
            v[11] = (k == 1);
            v[10] = win(k, 2, n + 1);
            v[9]  = win(k, n + 3, 2*n + 2);
            v[8]  = win(k, n + 4, 2*n + 3);
            v[7]  = win(k, n + 5, 2*n + 4);
            v[6]  = (k == 2*n + 5);
            v[5]  = win(k, 2*n + 7, 3*n + 6);
            v[4]  = win(k, 2*n + 8, 3*n + 7);
            v[3]  = win(k, 2*n + 9, 3*n + 8);
            v[2]  = win(k, 2*n + 10, 3*n + 9);
            v[1]  = win(k, 1, 3*n + 9);
            v[0]  = (k == 3*n + 10);
        end
        return v;
    endfunction

    function automatic bit m_idle();
        int k;
        k = cyc - m_c0;
        if (!have_run) return 1'b1;
        if (m_n == 0) return k >= 2;
        return k >= 3*m_n + 11;
    endfunction

    // Reference model: tracks accepted starts from the bench's own inputs
    // and queues the outputs each run must produce.
    always @(posedge clk) begin : model
        out_t e;
        if (reset) begin
            model_ok = 1'b1;
            have_run = 1'b0;
            runs_expected = runs_expected - done_q.size();
            done_q.delete();
            out_q.delete();
        end else if (model_ok && m_idle() && start) begin
            have_run = 1'b1;
            m_c0 = cyc;
            m_n = int'(addr_limit);
            run_id++;
            runs_expected++;
            if (m_n == 0) begin
                done_q.push_back(cyc + 1);
            end else begin
                for (int i = 0; i < m_n; i++) begin
                    e.cyc = cyc + 2*m_n + 10 + i;
                    e.idx = i;
                    out_q.push_back(e);
                end
                done_q.push_back(cyc + 3*m_n + 10);
            end
        end
        cyc++;
    end

    // Monitor: strobe windows, addresses, overlap, and queue pops.
    int cnt[12];
    int seen_id = 0;

    always @(negedge clk) begin : mon
        int k;
        int groups;
        logic [11:0] act;
        logic [11:0] ex;
        out_t e;
        int exp_cnt;
        if (model_ok) begin
            k = cyc - m_c0;
            act = {clr, max_en, sub_en, exp_en, acc_en, log_en,
                   presub_en, logsub_en, outexp_en, out_valid, busy, done};
            ex = have_run ? exp_strb(k, m_n) : 12'h000;
            check("strobes", {20'd0, act}, {20'd0, ex});

            if (!have_run) begin
                check("addr_rst", {24'd0, addr}, 0);
                check("sub0_rst", {24'd0, sub0_inp_addr}, 0);
                check("sub1_rst", {24'd0, sub1_inp_addr}, 0);
            end else if (k >= 1) begin
                check("addr", {24'd0, addr}, clampk(k, 1, m_n));
                check("sub0_addr", {24'd0, sub0_inp_addr}, clampk(k, m_n + 2, m_n));
                check("sub1_addr", {24'd0, sub1_inp_addr}, clampk(k, 2*m_n + 6, m_n));
            end

            if (run_id != seen_id) begin
                for (int b = 0; b < 12; b++) cnt[b] = 0;
                seen_id = run_id;
            end
            for (int b = 2; b < 12; b++) cnt[b] += int'(act[b]);

            groups = int'(max_en) + int'(sub_en | exp_en | acc_en) + int'(log_en)
                   + int'(presub_en | logsub_en | outexp_en | out_valid);
            if (groups != 0) check("phase_overlap", groups > 1, 0);

            if (out_valid) begin
                if (out_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    e = out_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_idx", {24'd0, out_idx}, e.idx);
                end
            end

            if (done) begin
                dones_seen++;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    for (int b = 2; b < 12; b++) begin
                        exp_cnt = (m_n == 0) ? 0 : ((b == 11 || b == 6) ? 1 : m_n);
                        check($sformatf("count_bit%0d", b), cnt[b], exp_cnt);
                    end
                end
            end
        end
    end

    task automatic pulse(input int n);
        @(negedge clk);
        start = 1'b1;
        addr_limit = n[AW-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (!m_idle() && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (!m_idle()) check("idle_wait", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r1;
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic runs: N=4, N=1, N=0
        pulse(4);
        wait_idle(100);
        pulse(1);
        wait_idle(50);
        pulse(0);
        wait_idle(20);
        repeat (2) @(negedge clk);

        // start held high across two runs; addr_limit disturbed during run 1
        @(negedge clk);
        start = 1'b1;
        addr_limit = 8'd4;
        @(negedge clk);
        r1 = m_c0;
        while (cyc < r1 + 5) @(negedge clk);
        addr_limit = 8'd7;
        while (cyc < r1 + 15) @(negedge clk);
        addr_limit = 8'd4;
        while (cyc < r1 + 30) @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        repeat (2) @(negedge clk);

        // Reset mid-run at cycle 10, restart at cycle 13
        pulse(4);
        r1 = m_c0;
        while (cyc < r1 + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        while (cyc < r1 + 13) @(negedge clk);
        start = 1'b1;
        addr_limit = 8'd4;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);

        // Random run lengths
        for (int i = 0; i < 50; i++) begin
            n = int'($urandom_range(1, 20));
            pulse(n);
            wait_idle(100);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_out", out_q.size(), 0);
        check("pending_done", done_q.size(), 0);
        check("done_count", dones_seen, runs_expected);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
